gpio_ahb_slave_if: RTL and testbench

AHB-Lite slave front end for the GPIO peripheral. It sits between the AHB interconnect (HSEL from the address decoder) and the GPIO register block. It converts pipelined AHB address/data phases into the GPIO's single-cycle `en/we/re/Addr/size/wd_data` strobes, registers read data, and turns the GPIO's `done`/`check` flags into HREADYOUT/HRESP. It also adds local protocol checks and a wait-state timeout.

---
 rtl/gpio_ahb_slave_if.sv | 192 +++++++++++++++++++
 tb/tb_gpio_ahb_slave_if.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ahb_slave_if.sv
// AHB-Lite slave front end for the GPIO register block.
// Converts pipelined AHB address/data phases into single-cycle GPIO strobes,
// registers read data, and maps GPIO done/check flags onto HREADYOUT/HRESP.
// Adds local size/alignment checks and a wait-state timeout.
module gpio_ahb_slave_if #(
  parameter int ADDR_LSB = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        en,
  output logic        we,
  output logic        re,
  output logic [2:0]  Addr,
  output logic [1:0]  size,
  output logic [31:0] wd_data,
  input  logic [31:0] rd_data,
  input  logic        done,
  input  logic        check
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_CHECK  = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic           check_base_q;
  logic [31:0]    hrdata_q;
  logic           en_q;
  logic           we_q;
  logic           re_q;
  logic [2:0]     addr_q;
  logic [1:0]     size_q;

  logic           perr_s;
  logic           hreadyout_s;
  logic           hresp_s;
  logic           valid_s;
  logic           illegal_s;
  logic           unused_s;

  // Size above word, or a halfword/word not aligned to its own size, is rejected locally.
  function automatic logic is_illegal(input logic [2:0] sz, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (sz)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Bus response decoded from state; CHECK depends on the live sticky check flag,
  // which only becomes valid after the GPIO has completed the access.
  always_comb begin
    perr_s      = check & ~check_base_q;
    hreadyout_s = 1'b1;
    hresp_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
      end
      ST_ACCESS: begin
        hreadyout_s = 1'b0;
        hresp_s     = 1'b0;
      end
      ST_CHECK: begin
        hreadyout_s = ~perr_s;
        hresp_s     = perr_s;
      end
      ST_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = 1'b1;
      end
      ST_ERR2: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b1;
      end
      default: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
      end
    endcase
  end

  assign valid_s   = HSEL & HREADY & HTRANS[1] & hreadyout_s;
  assign illegal_s = is_illegal(HSIZE, HADDR[1:0]);

  // Protocol FSM with registered GPIO strobes, read data and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      check_base_q <= 1'b0;
      hrdata_q     <= 32'd0;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      addr_q       <= 3'd0;
      size_q       <= 2'd0;
    end else begin
      case (state_q)
        ST_ACCESS: begin
          if (done) begin
            if (re_q) begin
              hrdata_q <= rd_data;
            end else begin
              hrdata_q <= hrdata_q;
            end
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= 3'd0;
            size_q  <= 2'd0;
            state_q <= ST_CHECK;
          end else if (cnt_q == CNT_LAST) begin
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= 3'd0;
            size_q  <= 2'd0;
            state_q <= ST_ERR1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_ERR1: begin
          state_q <= ST_ERR2;
        end
        ST_IDLE, ST_CHECK, ST_ERR2: begin
          if (valid_s) begin
            check_base_q <= check;
            if (illegal_s) begin
              state_q <= ST_ERR1;
            end else begin
              state_q <= ST_ACCESS;
              cnt_q   <= '0;
              en_q    <= 1'b1;
              we_q    <= HWRITE;
              re_q    <= ~HWRITE;
              addr_q  <= HADDR[ADDR_LSB+2:ADDR_LSB];
              size_q  <= HSIZE[1:0];
            end
          end else if (hreadyout_s) begin
            state_q <= ST_IDLE;
          end else begin
            // CHECK with a peripheral error continues into the second ERROR cycle
            state_q <= ST_ERR2;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_s;
  assign HRESP     = hresp_s;
  assign en        = en_q;
  assign we        = we_q;
  assign re        = re_q;
  assign Addr      = addr_q;
  assign size      = size_q;
  // Write data is only exposed to the GPIO while the access strobe is up.
  assign wd_data   = en_q ? HWDATA : 32'd0;

  assign unused_s  = ^{HADDR, HTRANS[0]};

endmodule

// File: tb/tb_gpio_ahb_slave_if.sv
// Directed self-checking bench for gpio_ahb_slave_if with a small GPIO stub.
module tb_gpio_ahb_slave_if;

  logic        clk;
  logic        rst_n;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        en;
  logic        we;
  logic        re;
  logic [2:0]  Addr;
  logic [1:0]  size;
  logic [31:0] wd_data;
  logic [31:0] rd_data;
  logic        done;
  logic        check;

  logic        gpio_rst_n;
  logic        stall;
  logic [31:0] gpio_out_a;
  logic [31:0] gpio_out_b;
  logic [31:0] gpio_in_b;

  int errors;
  int checks;

  gpio_ahb_slave_if #(.ADDR_LSB(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .en(en), .we(we),
    .re(re), .Addr(Addr), .size(size), .wd_data(wd_data), .rd_data(rd_data),
    .done(done), .check(check)
  );

  // Single slave on the bus: bus-wide ready is this slave's ready.
  assign HREADY = HREADYOUT;
  assign done   = ~stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GPIO stub read mux: idx1 input port B, idx4 out A, idx5 out B.
  always_comb begin
    rd_data = 32'd0;
    case (Addr)
      3'd1:    rd_data = gpio_in_b;
      3'd4:    rd_data = gpio_out_a;
      3'd5:    rd_data = gpio_out_b;
      default: rd_data = 32'd0;
    endcase
  end

  // GPIO stub registers: writes to input ports (idx 0/1) set the sticky check flag.
  always_ff @(posedge clk or negedge gpio_rst_n) begin
    if (!gpio_rst_n) begin
      gpio_out_a <= 32'd0;
      gpio_out_b <= 32'd0;
      check      <= 1'b0;
    end else if (en && done && we) begin
      case (Addr)
        3'd4:       gpio_out_a <= wd_data;
        3'd5:       gpio_out_b <= wd_data;
        3'd0, 3'd1: check      <= 1'b1;
        default:    check      <= check;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    HSEL   = 1'b1;
    HADDR  = a;
    HTRANS = 2'b10;
    HWRITE = wr;
    HSIZE  = sz;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = 32'd0;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gpio_rst_n = 1'b0; stall = 1'b0; gpio_in_b = 32'h3C;
    bus_idle();
    HWDATA = 32'hDEAD_BEEF;
    tick(); tick();
    checks++; if (HRDATA !== 32'd0) begin errors++; $display("FAIL reset_hrdata got %h want %h", HRDATA, 32'd0); end
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL reset_resp got %b want %b", {HREADYOUT, HRESP}, 2'b10); end
    checks++; if ({en, we, re, Addr, size} !== 8'd0) begin errors++; $display("FAIL reset_strobes got %h want %h", {en, we, re, Addr, size}, 8'd0); end
    checks++; if (wd_data !== 32'd0) begin errors++; $display("FAIL reset_wd_data got %h want %h", wd_data, 32'd0); end
    rst_n = 1'b1; gpio_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_trans();
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h10; HWRITE = 1'b1;
    tick();
    checks++; if ({HREADYOUT, HRESP, en} !== 3'b100) begin errors++; $display("FAIL busy_okay got %b want %b", {HREADYOUT, HRESP, en}, 3'b100); end
    bus_idle();
  endtask

  task automatic test_write_porta();
    addr_phase(32'h10, 1'b1, 3'b010);
    tick();
    bus_idle(); HWDATA = 32'h0000_00A5;
    #1;
    checks++; if ({en, we, re, Addr, size} !== {3'b110, 3'd4, 2'b10}) begin errors++; $display("FAIL wr_access got %b want %b", {en, we, re, Addr, size}, {3'b110, 3'd4, 2'b10}); end
    checks++; if (wd_data !== 32'hA5) begin errors++; $display("FAIL wr_wd_data got %h want %h", wd_data, 32'hA5); end
    checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL wr_access_wait got %b want %b", HREADYOUT, 1'b0); end
    tick();
    checks++; if ({HREADYOUT, HRESP, en} !== 3'b100) begin errors++; $display("FAIL wr_check got %b want %b", {HREADYOUT, HRESP, en}, 3'b100); end
    checks++; if (gpio_out_a !== 32'hA5) begin errors++; $display("FAIL wr_porta got %h want %h", gpio_out_a, 32'hA5); end
    tick();
  endtask

  task automatic test_read_portb();
    addr_phase(32'h04, 1'b0, 3'b010);
    tick();
    bus_idle();
    checks++; if ({en, we, re, Addr} !== {3'b101, 3'd1}) begin errors++; $display("FAIL rd_access got %b want %b", {en, we, re, Addr}, {3'b101, 3'd1}); end
    tick();
    checks++; if (HRDATA !== 32'h3C) begin errors++; $display("FAIL rd_hrdata got %h want %h", HRDATA, 32'h3C); end
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL rd_check got %b want %b", {HREADYOUT, HRESP}, 2'b10); end
    tick();
  endtask

  task automatic test_periph_error();
    addr_phase(32'h00, 1'b1, 3'b010);
    tick();
    bus_idle(); HWDATA = 32'h1;
    tick();
    checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin errors++; $display("FAIL perr_first got %b want %b", {HREADYOUT, HRESP}, 2'b01); end
    tick();
    checks++; if ({HREADYOUT, HRESP} !== 2'b11) begin errors++; $display("FAIL perr_second got %b want %b", {HREADYOUT, HRESP}, 2'b11); end
    tick();
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL perr_idle got %b want %b", {HREADYOUT, HRESP}, 2'b10); end
    // Same write again: check is already sticky so the access completes OKAY.
    addr_phase(32'h00, 1'b1, 3'b010);
    tick();
    bus_idle();
    tick();
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL perr_sticky got %b want %b", {HREADYOUT, HRESP}, 2'b10); end
    tick();
  endtask

  task automatic test_local_error();
    logic [31:0] la [2];
    logic [2:0]  ls [2];
    la[0] = 32'h10; ls[0] = 3'b011;
    la[1] = 32'h11; ls[1] = 3'b001;
    for (int i = 0; i < 2; i++) begin
      addr_phase(la[i], 1'b1, ls[i]);
      tick();
      bus_idle(); HWDATA = 32'hFFFF_FFFF;
      #1;
      checks++; if ({HREADYOUT, HRESP, en} !== 3'b010) begin errors++; $display("FAIL lerr_first%0d got %b want %b", i, {HREADYOUT, HRESP, en}, 3'b010); end
      tick();
      checks++; if ({HREADYOUT, HRESP, en} !== 3'b110) begin errors++; $display("FAIL lerr_second%0d got %b want %b", i, {HREADYOUT, HRESP, en}, 3'b110); end
      tick();
      checks++; if (gpio_out_a !== 32'hA5) begin errors++; $display("FAIL lerr_porta%0d got %h want %h", i, gpio_out_a, 32'hA5); end
    end
  endtask

  task automatic test_back_to_back();
    addr_phase(32'h10, 1'b1, 3'b010);
    tick();
    // Master holds the next address while the first data phase is stalled.
    addr_phase(32'h14, 1'b1, 3'b010); HWDATA = 32'h11;
    tick();
    checks++; if ({HREADYOUT, gpio_out_a, gpio_out_b} !== {1'b1, 32'h11, 32'h0}) begin errors++; $display("FAIL b2b_first got %h/%h want 11/0", gpio_out_a, gpio_out_b); end
    tick();
    bus_idle(); HWDATA = 32'h22;
    #1;
    checks++; if ({en, Addr, wd_data} !== {1'b1, 3'd5, 32'h22}) begin errors++; $display("FAIL b2b_second_access got %h want %h", {en, Addr, wd_data}, {1'b1, 3'd5, 32'h22}); end
    tick();
    checks++; if ({HREADYOUT, gpio_out_b} !== {1'b1, 32'h22}) begin errors++; $display("FAIL b2b_second got %h want %h", gpio_out_b, 32'h22); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    stall = 1'b1;
    addr_phase(32'h10, 1'b1, 3'b010);
    tick();
    bus_idle(); HWDATA = 32'h77;
    n = 0;
    while (en === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", n, 16); end
    checks++; if ({HREADYOUT, HRESP, en} !== 3'b010) begin errors++; $display("FAIL timeout_first got %b want %b", {HREADYOUT, HRESP, en}, 3'b010); end
    tick();
    checks++; if ({HREADYOUT, HRESP} !== 2'b11) begin errors++; $display("FAIL timeout_second got %b want %b", {HREADYOUT, HRESP}, 2'b11); end
    stall = 1'b0;
    tick();
    checks++; if (gpio_out_a !== 32'h11) begin errors++; $display("FAIL timeout_porta got %h want %h", gpio_out_a, 32'h11); end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    addr_phase(32'h10, 1'b1, 3'b010);
    tick();
    bus_idle(); HWDATA = 32'h99;
    rst_n = 1'b0;
    #1;
    checks++; if ({en, HREADYOUT, HRESP} !== 3'b010) begin errors++; $display("FAIL rstmid_resp got %b want %b", {en, HREADYOUT, HRESP}, 3'b010); end
    checks++; if ({HRDATA, wd_data} !== 64'd0) begin errors++; $display("FAIL rstmid_data got %h want %h", {HRDATA, wd_data}, 64'd0); end
    stall = 1'b0;
    tick();
    checks++; if (gpio_out_a !== 32'h11) begin errors++; $display("FAIL rstmid_nowrite got %h want %h", gpio_out_a, 32'h11); end
    rst_n = 1'b1;
    tick();
    gpio_in_b = 32'h5A;
    addr_phase(32'h04, 1'b0, 3'b010);
    tick();
    bus_idle();
    checks++; if ({en, re, Addr} !== {2'b11, 3'd1}) begin errors++; $display("FAIL rstmid_after got %b want %b", {en, re, Addr}, {2'b11, 3'd1}); end
    tick();
    checks++; if ({HREADYOUT, HRDATA} !== {1'b1, 32'h5A}) begin errors++; $display("FAIL rstmid_read got %h want %h", HRDATA, 32'h5A); end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_idle_trans();
    test_write_porta();
    test_read_portb();
    test_periph_error();
    test_local_error();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
